axis_lane_swap: RTL

Parametrised AXI4-Stream byte-lane reordering stage that converts between wire byte order and the core-native byte order of the Ethernet MAC and PCIe core streams. The swap mode is selectable per packet: none, full-beat byte reversal (Ethernet-style) or per-DWORD byte reversal (PCIe-style). The block sits between a MAC/PCIe core AXIS port and the adapter datapath as a fully registered, full-throughput pipeline stage with a skid buffer. Optional per-stage packet and beat statistics are provided.

---
 rtl/axis_lane_swap.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/axis_lane_swap.sv
// AXI4-Stream byte-lane reorder stage: pass, full-beat reverse or per-DWORD reverse,
// registered output plus skid buffer. Define LANE_SWAP_STATS_EN to build pkt_cnt/beat_cnt.
module axis_lane_swap #(
    parameter int DATA_WIDTH = 64,
    parameter int USER_WIDTH = 22,
    parameter int KEEP_WIDTH = DATA_WIDTH/8
) (
    input  logic                  clk156,
    input  logic                  sys_rst156,
    input  logic [1:0]            mode,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [KEEP_WIDTH-1:0] s_axis_tkeep,
    input  logic                  s_axis_tlast,
    input  logic [USER_WIDTH-1:0] s_axis_tuser,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
    output logic                  m_axis_tlast,
    output logic [USER_WIDTH-1:0] m_axis_tuser,
    output logic [1:0]            active_mode,
    output logic [31:0]           pkt_cnt,
    output logic [31:0]           beat_cnt
);

    typedef enum logic {IDLE = 1'b0, IN_PKT = 1'b1} state_t;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] data;
        logic [KEEP_WIDTH-1:0] keep;
        logic                  last;
        logic [USER_WIDTH-1:0] user;
    } beat_t;

    state_t                state_q, state_d;
    logic [1:0]            active_mode_q, active_mode_d;
    logic [1:0]            eff_mode_s;
    logic                  in_fire_s;
    logic                  out_free_s;
    logic                  out_valid_q, out_valid_d;
    logic                  skid_valid_q, skid_valid_d;
    logic                  tready_q, tready_d;
    beat_t                 out_beat_q, out_beat_d;
    beat_t                 skid_beat_q, skid_beat_d;
    beat_t                 in_beat_s;
    logic [DATA_WIDTH-1:0] rev_data_s, dw_data_s;
    logic [KEEP_WIDTH-1:0] rev_keep_s, dw_keep_s;

    assign in_fire_s  = s_axis_tvalid && tready_q;
    assign out_free_s = !out_valid_q || m_axis_tready;
    // The first beat of a packet uses the live mode input; later beats reuse the latched one.
    assign eff_mode_s = (state_q == IDLE) ? mode : active_mode_q;

    // Candidate lane permutations of the incoming beat
    always_comb begin
        rev_data_s = '0;
        rev_keep_s = '0;
        dw_data_s  = '0;
        dw_keep_s  = '0;
        for (int k = 0; k < KEEP_WIDTH; k++) begin
            rev_data_s[8*k +: 8] = s_axis_tdata[8*(KEEP_WIDTH-1-k) +: 8];
            rev_keep_s[k]        = s_axis_tkeep[KEEP_WIDTH-1-k];
            dw_data_s[8*k +: 8]  = s_axis_tdata[8*(4*(k/4) + 3 - (k%4)) +: 8];
            dw_keep_s[k]         = s_axis_tkeep[4*(k/4) + 3 - (k%4)];
        end
    end

    // Select the permutation for the beat being accepted
    always_comb begin
        in_beat_s      = '0;
        in_beat_s.last = s_axis_tlast;
        in_beat_s.user = s_axis_tuser;
        case (eff_mode_s)
            2'd1: begin
                in_beat_s.data = rev_data_s;
                in_beat_s.keep = rev_keep_s;
            end
            2'd2: begin
                in_beat_s.data = dw_data_s;
                in_beat_s.keep = dw_keep_s;
            end
            default: begin
                in_beat_s.data = s_axis_tdata;
                in_beat_s.keep = s_axis_tkeep;
            end
        endcase
    end

    // Packet FSM next state and mode latch
    always_comb begin
        state_d       = state_q;
        active_mode_d = active_mode_q;
        case (state_q)
            IDLE: begin
                if (in_fire_s) begin
                    active_mode_d = mode;
                    state_d       = s_axis_tlast ? IDLE : IN_PKT;
                end else begin
                    state_d = IDLE;
                end
            end
            IN_PKT: begin
                if (in_fire_s && s_axis_tlast) begin
                    state_d = IDLE;
                end else begin
                    state_d = IN_PKT;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output register and skid buffer next state; skid always drains ahead of new input
    always_comb begin
        out_valid_d  = out_valid_q;
        out_beat_d   = out_beat_q;
        skid_valid_d = skid_valid_q;
        skid_beat_d  = skid_beat_q;
        if (out_free_s) begin
            if (skid_valid_q) begin
                out_valid_d  = 1'b1;
                out_beat_d   = skid_beat_q;
                skid_valid_d = 1'b0;
            end else if (in_fire_s) begin
                out_valid_d = 1'b1;
                out_beat_d  = in_beat_s;
            end else begin
                out_valid_d = 1'b0;
            end
        end else if (in_fire_s) begin
            skid_valid_d = 1'b1;
            skid_beat_d  = in_beat_s;
        end else begin
            skid_valid_d = skid_valid_q;
        end
        tready_d = !skid_valid_d;
    end

    // State registers
    always_ff @(posedge clk156 or posedge sys_rst156) begin
        if (sys_rst156) begin
            state_q       <= IDLE;
            active_mode_q <= 2'd0;
            out_valid_q   <= 1'b0;
            out_beat_q    <= '0;
            skid_valid_q  <= 1'b0;
            skid_beat_q   <= '0;
            tready_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            active_mode_q <= active_mode_d;
            out_valid_q   <= out_valid_d;
            out_beat_q    <= out_beat_d;
            skid_valid_q  <= skid_valid_d;
            skid_beat_q   <= skid_beat_d;
            tready_q      <= tready_d;
        end
    end

    assign s_axis_tready = tready_q;
    assign m_axis_tvalid = out_valid_q;
    assign m_axis_tdata  = out_beat_q.data;
    assign m_axis_tkeep  = out_beat_q.keep;
    assign m_axis_tlast  = out_beat_q.last;
    assign m_axis_tuser  = out_beat_q.user;
    assign active_mode   = active_mode_q;

`ifdef LANE_SWAP_STATS_EN
    logic [31:0] pkt_cnt_q, pkt_cnt_d;
    logic [31:0] beat_cnt_q, beat_cnt_d;

    // Accepted-beat and accepted-packet counters; both wrap silently
    always_comb begin
        pkt_cnt_d  = pkt_cnt_q;
        beat_cnt_d = beat_cnt_q;
        if (in_fire_s) begin
            beat_cnt_d = beat_cnt_q + 32'd1;
            if (s_axis_tlast) begin
                pkt_cnt_d = pkt_cnt_q + 32'd1;
            end else begin
                pkt_cnt_d = pkt_cnt_q;
            end
        end else begin
            beat_cnt_d = beat_cnt_q;
        end
    end

    // Counter registers
    always_ff @(posedge clk156 or posedge sys_rst156) begin
        if (sys_rst156) begin
            pkt_cnt_q  <= 32'd0;
            beat_cnt_q <= 32'd0;
        end else begin
            pkt_cnt_q  <= pkt_cnt_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

    assign pkt_cnt  = pkt_cnt_q;
    assign beat_cnt = beat_cnt_q;
`else
    assign pkt_cnt  = 32'd0;
    assign beat_cnt = 32'd0;
`endif

endmodule
